// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension pipeline.
//   immsrc_e : immediate format select codes carried on the immsrc port
//   state_e  : occupancy of the two-entry output buffer
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/imm_format.sv
// Combinational immediate decoder: picks the immediate field for the selected
// format and sign-extends it from instr[31] up to XLEN bits.
// Ports:
//   instr   in  32    raw instruction word
//   immsrc  in  3     format select (imm_pkg::immsrc_e)
//   imm     out XLEN  sign-extended immediate, 0 for an undefined code
//   illegal out 1     immsrc is not a defined format
module imm_format #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  import imm_pkg::*;

  logic [31:0] w_imm32;
  // Opcode bits carry no immediate information in any format.
  logic        w_unused_opcode;

  assign w_unused_opcode = ^instr[6:0];

  always_comb begin
    w_imm32 = '0;
    illegal = 1'b0;
    case (immsrc_e'(immsrc))
      IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      IMM_U:   w_imm32 = {instr[31:12], 12'b0};
      default: illegal = 1'b1;
    endcase
  end

  // Upper bits beyond 32 replicate instr[31]; an illegal code forces all zero.
  always_comb begin
    imm = {XLEN{instr[31]}};
    imm[31:0] = w_imm32;
    if (illegal) imm = '0;
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension stage with a two-entry (main + skid) valid/ready buffer.
// Ports:
//   clk, reset (sync, active-high), flush (drop all entries)
//   in_valid/in_ready, instr, immsrc, in_tag   : upstream side
//   out_valid/out_ready, immext, out_tag, illegal : downstream side
//
// state    | meaning
// ST_EMPTY | no entry held, outputs zero
// ST_ONE   | main register holds the presented entry
// ST_FULL  | main presented, skid holds the next entry, in_ready low
module imm_ext_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic [TAGW-1:0] out_tag,
  output logic            illegal
);
  import imm_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            ill;
  } entry_t;

  state_e          r_state;
  entry_t          r_main;
  entry_t          r_skid;
  logic            r_in_ready;

  entry_t          w_in;
  logic [XLEN-1:0] w_imm;
  logic            w_ill;
  logic            w_in_xfer;
  logic            w_out_xfer;

  imm_format #(.XLEN(XLEN)) u_fmt (
    .instr   (instr),
    .immsrc  (immsrc),
    .imm     (w_imm),
    .illegal (w_ill)
  );

  assign w_in       = '{imm: w_imm, tag: in_tag, ill: w_ill};
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = (r_state != ST_EMPTY) & out_ready;

  // Main is zeroed whenever the buffer drains so the outputs read 0 when idle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state    <= ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= ~reset;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= w_in;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            r_skid     <= w_in;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer && !w_in_xfer) begin
            r_main  <= '0;
            r_state <= ST_EMPTY;
          end else if (w_in_xfer && w_out_xfer) begin
            r_main <= w_in;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_skid  <= '0;
            r_state <= ST_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign immext    = r_main.imm;
  assign out_tag   = r_main.tag;
  assign illegal   = r_main.ill;

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAGW, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discards all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream presents an instruction.
REQ-007 SHALL have port in_ready  output  1  block can accept; driven only from registered state.
REQ-008 SHALL have port instr  input  32  raw instruction word.
REQ-009 SHALL have port immsrc  input  3  format select: I, S, B, J, U; other codes illegal.
REQ-010 SHALL have port in_tag  input  TAGW  sideband, passed through unchanged.
REQ-011 SHALL have port out_valid  output  1  immext/out_tag/illegal valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts.
REQ-013 SHALL have port immext  output  XLEN  sign-extended immediate.
REQ-014 SHALL have port out_tag  output  TAGW  tag of the presented entry.
REQ-015 SHALL have port illegal  output  1  presented entry used an undefined immsrc code.

Function
REQ-016 Formats SHALL be: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); U = sext({instr[31:12],12'b0}).
REQ-017 Sign extension SHALL replicate instr[31] up to bit XLEN-1 for every format, U included.
REQ-018 Undefined immsrc SHALL yield immext = 0 and illegal = 1; the entry still flows through the handshake.
REQ-019 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 Latency SHALL be exactly one cycle: an entry accepted in cycle N is presented in cycle N+1 at the earliest.
REQ-021 Storage SHALL be a main output register plus one skid register (2 entries); states EMPTY (0), ONE (main valid), FULL (main + skid valid).
REQ-022 Transitions: EMPTY -in-> ONE; ONE -in & !out-> FULL; ONE -out & !in-> EMPTY; ONE -in & out-> ONE; FULL -out-> ONE (skid moves to main); all others hold.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, so full throughput is sustained with out_ready held high.
REQ-024 Presented outputs SHALL stay stable while out_valid && !out_ready.
REQ-025 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated except on flush or reset.
REQ-026 flush SHALL move to EMPTY on the next edge, and any input transfer in the same cycle SHALL be discarded (flush wins).
REQ-027 When out_valid = 0, immext, out_tag and illegal SHALL be 0.

Reset
REQ-028 On reset: state EMPTY, out_valid = 0, immext = 0, out_tag = 0, illegal = 0, in_ready = 0 during the reset cycle and 1 on the first cycle after.
REQ-029 Reset asserted mid-operation SHALL discard all entries regardless of in_valid, out_ready or flush.

Structure
REQ-030 Package imm_pkg SHALL hold the immsrc encoding (I = 000, S = 001, B = 010, J = 011, U = 100) as a typedef enum, plus the state typedef.
REQ-031 A combinational sub-module imm_format (instr, immsrc -> XLEN immediate, illegal) SHALL be instantiated once, at the input side, before the registers.

Verification
REQ-032 XLEN = 32, I, instr 0xFFF00093 -> immext 0xFFFFFFFF one cycle later; S, 0xFE20AE23 -> 0xFFFFFFFC.
REQ-033 B, 0xFE000CE3 -> 0xFFFFFFF8; J, 0x001000EF -> 0x00000800; U, 0x123450B7 -> 0x12345000; immsrc = 111 -> immext 0, illegal 1.
REQ-034 XLEN = 64, U, 0x800000B7 -> 0xFFFFFFFF80000000; I, 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
REQ-035 Backpressure: tags 1, 2, 3 sent back-to-back with out_ready = 0 -> in_ready drops after 2 accepts; releasing out_ready delivers 1, 2, then 3 in order with no loss.
REQ-036 Flush while FULL with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the flushed input is never presented.
REQ-037 Reset asserted while FULL -> out_valid = 0 and all outputs 0 next cycle; a stream of 8 entries with out_ready = 1 then shows 1 output per cycle.
